rr_arbiter: RTL

- Round-robin arbiter that shares one counter-style resource among N_REQ requesters.
- Grants exactly one requester at a time, rotating priority on every release.
- A per-grant hold counter bounds occupancy and forces preemption, so no requester can starve the others.
- The en input freezes the arbiter, mirroring the enable semantics of the shared counter.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int hold_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after start, wrapping modulo N_REQ.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  // start is always below N_REQ, so one subtraction is enough to wrap.
  function automatic int wrap(input int v);
    return (v >= N_REQ) ? v - N_REQ : v;
  endfunction

  // Scan from the far end so the nearest requester after start overwrites the rest.
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IDX_W'(wrap(int'(start) + k))]) begin
        any = 1'b1;
        win = IDX_W'(wrap(int'(start) + k));
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded grant occupancy; all outputs registered.
// en=0 freezes every register; a release re-arbitrates with no idle bubble.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDX_W    = idx_w(N_REQ),
  localparam int HOLD_W   = hold_w(MAX_HOLD)
) (
  input  logic              clk,
  input  logic              rst_aL,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [HOLD_W-1:0] hold_cnt
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_start;
  logic [IDX_W-1:0] win_idle;
  logic [IDX_W-1:0] win_rel;
  logic             any_idle;
  logic             any_rel;
  logic             rel;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign nxt_start = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign rel       = !req[gnt_idx] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
    .req   (req),
    .start (ptr),
    .win   (win_idle),
    .any   (any_idle)
  );

  // Releasing requester sits last in this order, so it only wins when alone.
  rr_pick #(.N_REQ(N_REQ)) u_pick_rel (
    .req   (req),
    .start (nxt_start),
    .win   (win_rel),
    .any   (any_rel)
  );

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      hold_cnt  <= '0;
    end else if (en) begin
      case (state)
        ARB_IDLE: begin
          if (any_idle) begin
            state     <= ARB_GRANT;
            gnt_idx   <= win_idle;
            hold_cnt  <= '0;
            gnt       <= onehot(win_idle);
            gnt_valid <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!rel) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else begin
            ptr      <= nxt_start;
            hold_cnt <= '0;
            if (any_rel) begin
              gnt_idx <= win_rel;
              gnt     <= onehot(win_rel);
            end else begin
              state     <= ARB_IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_aL) $onehot0(gnt));
  a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_aL) gnt_valid == (|gnt));

endmodule
